// File: rtl/cnn_kernel_load_sequencer.sv
// Streams CNN kernel stages K0..K5 and FC weights W from weight memory into the shift-chain storage.
// Define CNN_LDR_DONE_CHECK_EN to check each stage's load_done flag and report it on err/err_stage.
module cnn_kernel_load_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int LEN_K0    = 90,
    parameter int LEN_K1    = 900,
    parameter int LEN_K2    = 900,
    parameter int LEN_K3    = 900,
    parameter int LEN_K4    = 900,
    parameter int LEN_K5    = 900,
    parameter int LEN_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [6:0]        stage_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ker_data,
    output logic [5:0]        load_k,
    output logic              load_w,
    input  logic [6:0]        load_done,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic [2:0]        err_stage
);
    // state  | meaning
    // IDLE   | waiting for start
    // READ   | one memory read per cycle for the active stage
    // GAP    | no read; carries the stage's last load strobe
    // FIN    | done pulse, back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_FIN} state_t;

    localparam logic [2:0] NONE = 3'd7;

    function automatic int stage_len(input logic [2:0] s);
        case (s)
            3'd0:    return LEN_K0;
            3'd1:    return LEN_K1;
            3'd2:    return LEN_K2;
            3'd3:    return LEN_K3;
            3'd4:    return LEN_K4;
            3'd5:    return LEN_K5;
            3'd6:    return LEN_W;
            default: return 0;
        endcase
    endfunction

    function automatic int max_len();
        int m;
        m = 1;
        for (int i = 0; i < 7; i++)
            if (stage_len(3'(i)) > m) m = stage_len(3'(i));
        return m;
    endfunction

    localparam int MAX_LEN = max_len();
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // Disabled stages still occupy their address range.
    function automatic logic [ADDR_W-1:0] stage_base(input logic [2:0] s);
        int acc;
        acc = BASE_ADDR;
        for (int i = 0; i < 7; i++)
            if (i < int'(s)) acc += stage_len(3'(i));
        return ADDR_W'(acc);
    endfunction

    function automatic logic [2:0] find_stage(input logic [6:0] en, input int from);
        logic [2:0] r;
        r = NONE;
        for (int i = 6; i >= 0; i--)
            if (en[i] && i >= from) r = 3'(i);
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [2:0]       stage_idx, stage_nxt, sel;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [6:0]       en_q, en_nxt;
    logic             rd_valid;
    logic [2:0]       rd_stage;
    logic             aborted_q;

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_idx;
        cnt_nxt   = cnt;
        en_nxt    = en_q;
        mem_rd_en = 1'b0;
        sel       = NONE;
        case (state)
            S_IDLE: begin
                if (start) begin
                    en_nxt  = stage_en;
                    sel     = find_stage(stage_en, 0);
                    cnt_nxt = '0;
                    if (sel == NONE) begin
                        state_nxt = S_FIN;
                        stage_nxt = '0;
                    end else begin
                        state_nxt = S_READ;
                        stage_nxt = sel;
                    end
                end
            end
            S_READ: begin
                mem_rd_en = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(stage_len(stage_idx) - 1)) begin
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_GAP: begin
                cnt_nxt = '0;
                if (abort) begin
                    state_nxt = S_IDLE;
                    stage_nxt = '0;
                end else begin
                    sel = find_stage(en_q, int'(stage_idx) + 1);
                    if (sel == NONE) begin
                        state_nxt = S_FIN;
                        stage_nxt = '0;
                    end else begin
                        state_nxt = S_READ;
                        stage_nxt = sel;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                stage_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stage_idx <= '0;
            cnt       <= '0;
            en_q      <= '0;
        end else begin
            state     <= state_nxt;
            stage_idx <= stage_nxt;
            cnt       <= cnt_nxt;
            en_q      <= en_nxt;
        end
    end

    // An aborted read's data never produces a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_stage  <= '0;
            aborted_q <= 1'b0;
        end else begin
            rd_valid  <= mem_rd_en && !abort;
            rd_stage  <= stage_idx;
            aborted_q <= abort && (state != S_IDLE);
        end
    end

    always_comb begin
        load_k = '0;
        load_w = 1'b0;
        if (rd_valid) begin
            if (rd_stage == 3'd6) load_w = 1'b1;
            else                  load_k = 6'b1 << rd_stage;
        end
    end

    assign mem_addr = stage_base(stage_idx) + ADDR_W'(cnt);
    assign ker_data = mem_rdata;
    assign busy     = (state == S_READ) || (state == S_GAP);
    assign done     = (state == S_FIN) && !abort;
    assign aborted  = aborted_q;

`ifdef CNN_LDR_DONE_CHECK_EN
    logic       chk_pending;
    logic [2:0] chk_stage;
    logic       err_q;
    logic [2:0] err_stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_pending <= 1'b0;
            chk_stage   <= '0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            chk_pending <= (state == S_GAP) && !abort;
            chk_stage   <= stage_idx;
            if (state == S_IDLE && start) begin
                err_q       <= 1'b0;
                err_stage_q <= '0;
            end else if (chk_pending && !load_done[chk_stage]) begin
                err_q <= 1'b1;
                if (!err_q) err_stage_q <= chk_stage;
            end
        end
    end

    assign err       = err_q;
    assign err_stage = err_stage_q;
`else
    logic unused_load_done;
    assign unused_load_done = ^load_done;
    assign err              = 1'b0;
    assign err_stage        = 3'd0;
`endif

endmodule

// File: tb/tb_cnn_kernel_load_sequencer.sv
// Bench for cnn_kernel_load_sequencer: two instances (all LEN=3, and LEN_W=2) driven in lockstep.
module tb_cnn_kernel_load_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [6:0]  stage_en, load_done;
    logic        rd_en     [2];
    logic [15:0] addr      [2];
    logic [31:0] rdata     [2];
    logic [31:0] kdata     [2];
    logic [5:0]  load_k    [2];
    logic        load_w    [2];
    logic        busy      [2];
    logic        done      [2];
    logic        aborted   [2];
    logic        err       [2];
    logic [2:0]  err_stage [2];

    int checks = 0;
    int failures = 0;
    int lens [2][7];
    int exp_addr [2][$];
    int exp_stg  [2][$];

    typedef struct {
        logic [6:0] en;
        int         pulse;
        int         done_a, done_b, str_a, str_b;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    cnn_kernel_load_sequencer #(
        .LEN_K0(3), .LEN_K1(3), .LEN_K2(3), .LEN_K3(3), .LEN_K4(3), .LEN_K5(3), .LEN_W(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stage_en(stage_en),
        .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]), .ker_data(kdata[0]),
        .load_k(load_k[0]), .load_w(load_w[0]), .load_done(load_done), .busy(busy[0]),
        .done(done[0]), .aborted(aborted[0]), .err(err[0]), .err_stage(err_stage[0])
    );

    cnn_kernel_load_sequencer #(
        .LEN_K0(3), .LEN_K1(3), .LEN_K2(3), .LEN_K3(3), .LEN_K4(3), .LEN_K5(3), .LEN_W(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stage_en(stage_en),
        .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]), .ker_data(kdata[1]),
        .load_k(load_k[1]), .load_w(load_w[1]), .load_done(load_done), .busy(busy[1]),
        .done(done[1]), .aborted(aborted[1]), .err(err[1]), .err_stage(err_stage[1])
    );

    // Weight memory: word content encodes its address.
    always @(posedge clk) begin
        if (rd_en[0]) rdata[0] <= {16'hC0DE, addr[0]};
        if (rd_en[1]) rdata[1] <= {16'hC0DE, addr[1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string name);
        int rd_i [2];
        int st_i [2];
        int dc   [2];
        int viol [2];
        logic prev_rd [2];
        logic [6:0] strobe;
        int base;
        for (int d = 0; d < 2; d++) begin
            exp_addr[d].delete();
            exp_stg[d].delete();
            base = 0;
            for (int s = 0; s < 7; s++) begin
                if (v.en[s])
                    for (int i = 0; i < lens[d][s]; i++) begin
                        exp_addr[d].push_back(base + i);
                        exp_stg[d].push_back(s);
                    end
                base += lens[d][s];
            end
            rd_i[d] = 0; st_i[d] = 0; dc[d] = -1; viol[d] = 0; prev_rd[d] = 1'b0;
        end
        stage_en = v.en;
        start = 1'b1;
        tick();
        start = 1'b0;
        stage_en = ~v.en;
        for (int c = 1; c <= 200; c++) begin
            if (c == v.pulse) begin
                start = 1'b1;
                stage_en = 7'h7F;
            end else begin
                start = 1'b0;
            end
            for (int d = 0; d < 2; d++) begin
                if (dc[d] < 0) begin
                    if (rd_en[d]) begin
                        if (rd_i[d] >= exp_addr[d].size()) viol[d]++;
                        else if (int'(addr[d]) != exp_addr[d][rd_i[d]]) viol[d]++;
                        rd_i[d]++;
                    end
                    strobe = {load_w[d], load_k[d]};
                    if (strobe != 7'd0) begin
                        if (st_i[d] >= exp_stg[d].size()) viol[d]++;
                        else if (strobe != (7'b1 << exp_stg[d][st_i[d]])) viol[d]++;
                        else if (kdata[d] != {16'hC0DE, 16'(exp_addr[d][st_i[d]])}) viol[d]++;
                        st_i[d]++;
                    end
                    if ((strobe != 7'd0) != prev_rd[d]) viol[d]++;
                    prev_rd[d] = rd_en[d];
                    if (done[d]) begin
                        dc[d] = c;
                        if (busy[d]) viol[d]++;
                    end else if (!busy[d]) begin
                        viol[d]++;
                    end
                    if (aborted[d]) viol[d]++;
                end
            end
            if (dc[0] >= 0 && dc[1] >= 0) break;
            tick();
        end
        start = 1'b0;
        tick();
        check({name, "_done_is_pulse"}, int'(done[0] | done[1]), 0);
        check({name, "_a_done_cycle"}, dc[0], v.done_a);
        check({name, "_b_done_cycle"}, dc[1], v.done_b);
        check({name, "_a_strobes"}, st_i[0], v.str_a);
        check({name, "_b_strobes"}, st_i[1], v.str_b);
        check({name, "_a_reads"}, rd_i[0], v.str_a);
        check({name, "_b_reads"}, rd_i[1], v.str_b);
        check({name, "_a_violations"}, viol[0], 0);
        check({name, "_b_violations"}, viol[1], 0);
    endtask

    initial begin
        int cnt;
        lens[0] = '{3, 3, 3, 3, 3, 3, 3};
        lens[1] = '{3, 3, 3, 3, 3, 3, 2};
        vecs[0] = '{7'h7F, 0, 29, 28, 21, 20};
        vecs[1] = '{7'h41, 0,  9,  8,  6,  5};
        vecs[2] = '{7'h00, 0,  1,  1,  0,  0};
        vecs[3] = '{7'h04, 0,  5,  5,  3,  3};
        vecs[4] = '{7'h40, 0,  5,  4,  3,  2};
        vecs[5] = '{7'h2A, 0, 13, 13,  9,  9};
        vecs[6] = '{7'h41, 3,  9,  8,  6,  5};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stage_en = 7'd0; load_done = 7'h7F;
        repeat (3) tick();
        check("rst_addr", int'(addr[0]), 0);
        check("rst_rd_en", int'(rd_en[0]), 0);
        check("rst_load_k", int'(load_k[0]), 0);
        check("rst_load_w", int'(load_w[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_done", int'(done[0]), 0);
        check("rst_aborted", int'(aborted[0]), 0);
        check("rst_err", int'(err[0]), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("vec%0d", i));

        // abort during the 2nd K1 read (cycle 6, address 4)
        stage_en = 7'h7F; start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        check("abort_pre_addr", int'(addr[0]), 4);
        check("abort_pre_rd", int'(rd_en[0]), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_load_k", int'(load_k[0]), 0);
        check("abort_rd_en", int'(rd_en[0]), 0);
        check("abort_a_pulse", int'(aborted[0]), 1);
        check("abort_b_pulse", int'(aborted[1]), 1);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_done", int'(done[0]), 0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (done[0] || done[1] || aborted[0] || rd_en[0]) cnt++;
        end
        check("abort_quiet_after", cnt, 0);
        run(vecs[0], "restart");

        abort = 1'b1; tick(); abort = 1'b0;
        check("idle_abort_ignored", int'(aborted[0]), 0);

        // abort arriving in FIN suppresses done
        stage_en = 7'h00; start = 1'b1; tick(); start = 1'b0;
        abort = 1'b1; #1;
        check("fin_abort_no_done", int'(done[0]), 0);
        tick(); abort = 1'b0;
        check("fin_abort_pulse", int'(aborted[0]), 1);
        check("fin_abort_idle_done", int'(done[0]), 0);

        load_done = 7'b1101011;
        run(vecs[0], "bad_done");
`ifdef CNN_LDR_DONE_CHECK_EN
        check("err_a_set", int'(err[0]), 1);
        check("err_a_stage", int'(err_stage[0]), 2);
        check("err_b_set", int'(err[1]), 1);
        check("err_b_stage", int'(err_stage[1]), 2);
`else
        check("err_a_tied", int'(err[0]), 0);
        check("err_stage_a_tied", int'(err_stage[0]), 0);
`endif
        load_done = 7'h7F;
        run(vecs[3], "err_clear_run");
        check("err_a_cleared", int'(err[0]), 0);
        check("err_b_cleared", int'(err[1]), 0);

        // asynchronous reset in the GAP cycle of K0
        stage_en = 7'h7F; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("pre_reset_strobe", int'(load_k[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_load_k", int'(load_k[0]), 0);
        check("async_rst_addr", int'(addr[0]), 0);
        check("async_rst_busy", int'(busy[0]), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run(vecs[1], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
